// File: rtl/ehl_ahb_pkg.sv
// Shared AHB encodings and burst helpers for the ehl_ahb_matrix slave-layer arbiter.
package ehl_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Undefined-length and single transfers count as one beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ehl_ahb_matrix_arb_if.sv
// Request/grant bundle between the masters' route filters and one slave-layer arbiter.
interface ehl_ahb_matrix_arb_if #(
  parameter int unsigned MNUM   = 4,
  parameter int unsigned IW     = 2,
  parameter int unsigned HOLD_W = 4
);
  logic [MNUM-1:0]   m_req;
  logic [2*MNUM-1:0] m_htrans;
  logic [3*MNUM-1:0] m_hburst;
  logic [MNUM-1:0]   m_hlock;
  logic              hready;
  logic              rr_en;
  logic [HOLD_W-1:0] hold_max;
  logic [MNUM-1:0]   a_grant;
  logic [IW-1:0]     a_idx;
  logic [MNUM-1:0]   d_grant;
  logic [IW-1:0]     d_idx;
  logic              d_valid;

  modport master (
    output m_req, m_htrans, m_hburst, m_hlock, hready, rr_en, hold_max,
    input  a_grant, a_idx, d_grant, d_idx, d_valid
  );

  modport slave (
    input  m_req, m_htrans, m_hburst, m_hlock, hready, rr_en, hold_max,
    output a_grant, a_idx, d_grant, d_idx, d_valid
  );
endinterface

// File: rtl/ehl_rr_prio_sel.sv
// Combinational MNUM-way selector: fixed lowest-index priority or round-robin from ptr+1.
module ehl_rr_prio_sel #(
  parameter int unsigned MNUM = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [MNUM-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_rr_en,
  output logic [MNUM-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  import ehl_ahb_pkg::*;

  localparam logic [MNUM-1:0] ONE = MNUM'(1);

  int unsigned     w_cand;
  logic [MNUM-1:0] w_mask;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    w_mask = '0;
    for (int unsigned k = 0; k < MNUM; k++) begin
      w_cand = i_rr_en ? (32'(i_ptr) + 32'd1 + k) % MNUM : k;
      w_mask = ONE << w_cand;
      if (!o_any && ((i_req & w_mask) != '0)) begin
        o_any = 1'b1;
        o_gnt = w_mask;
        o_idx = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/ehl_ahb_matrix_arb.sv
// Per-slave-layer AHB arbiter: registered address-phase owner with burst/lock/INCR-hold
// handling, plus the data-phase owner used by the read-data and response return mux.
module ehl_ahb_matrix_arb
  import ehl_ahb_pkg::*;
#(
  parameter int unsigned MNUM   = 4,
  parameter int unsigned IW     = 2,
  parameter int unsigned HOLD_W = 4
) (
  input logic               hclk,
  input logic               hreset,
  ehl_ahb_matrix_arb_if.slave bus
);

  logic [MNUM-1:0]   r_a_grant;
  logic [IW-1:0]     r_a_idx;
  logic [MNUM-1:0]   r_d_grant;
  logic [IW-1:0]     r_d_idx;
  logic [IW-1:0]     r_ptr;
  logic [3:0]        r_cnt;
  logic [HOLD_W-1:0] r_hold;

  logic              w_owner;
  logic [2*MNUM-1:0] w_ht_sh;
  logic [3*MNUM-1:0] w_hb_sh;
  logic [MNUM-1:0]   w_lk_sh;
  htrans_e           w_htrans;
  logic [2:0]        w_hburst;
  logic              w_hlock;
  logic [3:0]        w_cnt_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_incr_act;
  logic              w_hold_hit;
  logic              w_locked;
  logic              w_arb;
  logic              w_data;
  logic [MNUM-1:0]   w_sel_gnt;
  logic [IW-1:0]     w_sel_idx;
  logic              w_sel_any;

  ehl_rr_prio_sel #(.MNUM(MNUM), .IW(IW)) u_sel (
    .i_req   (bus.m_req),
    .i_ptr   (r_ptr),
    .i_rr_en (bus.rr_en),
    .o_gnt   (w_sel_gnt),
    .o_idx   (w_sel_idx),
    .o_any   (w_sel_any)
  );

  assign w_owner  = |r_a_grant;
  assign w_ht_sh  = bus.m_htrans >> (32'd2 * 32'(r_a_idx));
  assign w_hb_sh  = bus.m_hburst >> (32'd3 * 32'(r_a_idx));
  assign w_lk_sh  = bus.m_hlock >> r_a_idx;
  assign w_htrans = w_owner ? htrans_e'(w_ht_sh[1:0]) : HTRANS_IDLE;
  assign w_hburst = w_owner ? w_hb_sh[2:0] : HBURST_SINGLE;
  assign w_hlock  = w_owner & w_lk_sh[0];

  // Lock is judged on the post-beat counters so a burst's first NONSEQ already holds the slave.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_hold_nxt = r_hold;
    unique case (w_htrans)
      HTRANS_NONSEQ: begin
        w_cnt_nxt  = 4'(burst_beats(w_hburst) - 5'd1);
        w_hold_nxt = '0;
      end
      HTRANS_SEQ: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 4'd1;
        if (w_hburst == HBURST_INCR) w_hold_nxt = HOLD_W'(r_hold + 1'b1);
      end
      HTRANS_IDLE: begin
        w_cnt_nxt  = '0;
        w_hold_nxt = '0;
      end
      HTRANS_BUSY: begin
        w_cnt_nxt  = r_cnt;
        w_hold_nxt = r_hold;
      end
    endcase
  end

  assign w_incr_act = (w_hburst == HBURST_INCR) && (w_htrans != HTRANS_IDLE);
  assign w_hold_hit = (bus.hold_max != '0) && (w_hold_nxt == bus.hold_max);
  assign w_locked   = w_owner && (w_hlock || (w_cnt_nxt != '0) || (w_incr_act && !w_hold_hit));
  assign w_arb      = bus.hready && !w_locked;
  assign w_data     = (w_htrans == HTRANS_NONSEQ) || (w_htrans == HTRANS_SEQ);

  // Hold count restarts at every arbitration so a re-granted INCR owner gets a fresh window.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_a_grant <= '0;
      r_a_idx   <= '0;
      r_d_grant <= '0;
      r_d_idx   <= '0;
      r_ptr     <= IW'(MNUM - 1);
      r_cnt     <= '0;
      r_hold    <= '0;
    end else if (bus.hready) begin
      r_cnt  <= w_cnt_nxt;
      r_hold <= w_arb ? '0 : w_hold_nxt;
      if (w_data) begin
        r_d_grant <= r_a_grant;
        r_d_idx   <= r_a_idx;
      end else begin
        r_d_grant <= '0;
        r_d_idx   <= '0;
      end
      if (w_arb) begin
        r_a_grant <= w_sel_gnt;
        r_a_idx   <= w_sel_idx;
        if (w_sel_any) r_ptr <= w_sel_idx;
      end
    end
  end

  assign bus.a_grant = r_a_grant;
  assign bus.a_idx   = r_a_idx;
  assign bus.d_grant = r_d_grant;
  assign bus.d_idx   = r_d_idx;
  assign bus.d_valid = |r_d_grant;

endmodule

// File: tb/tb_ehl_ahb_matrix_arb.sv
// Directed vector bench for ehl_ahb_matrix_arb (MNUM=4): table of per-edge stimulus with
// expected grants, followed by an asynchronous mid-burst reset sequence.
module tb_ehl_ahb_matrix_arb;

  localparam logic [1:0] IDL = 2'd0;
  localparam logic [1:0] BSY = 2'd1;
  localparam logic [1:0] NS  = 2'd2;
  localparam logic [1:0] SQ  = 2'd3;

  logic hclk;
  logic hreset;
  int   checks;
  int   errors;

  ehl_ahb_matrix_arb_if #(.MNUM(4), .IW(2), .HOLD_W(4)) bus ();

  ehl_ahb_matrix_arb #(.MNUM(4), .IW(2), .HOLD_W(4)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    bit         rs;
    logic       rr;
    logic [3:0] req;
    logic [1:0] ht;
    logic [2:0] hb;
    logic [3:0] lk;
    logic       rdy;
    logic [3:0] hmax;
    logic [3:0] eg;
    logic [3:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rs, input logic rr, input logic [3:0] req,
                              input logic [1:0] ht, input logic [2:0] hb, input logic [3:0] lk,
                              input logic rdy, input logic [3:0] hmax,
                              input logic [3:0] eg, input logic [3:0] ed);
    vec_t t;
    t.rs = rs; t.rr = rr; t.req = req; t.ht = ht; t.hb = hb; t.lk = lk;
    t.rdy = rdy; t.hmax = hmax; t.eg = eg; t.ed = ed;
    vecs.push_back(t);
  endfunction

  function automatic logic [1:0] oh2idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] ed);
    chk({tag, " a_grant"}, 32'(bus.a_grant), 32'(eg));
    chk({tag, " a_idx"},   32'(bus.a_idx),   32'(oh2idx(eg)));
    chk({tag, " d_grant"}, 32'(bus.d_grant), 32'(ed));
    chk({tag, " d_idx"},   32'(bus.d_idx),   32'(oh2idx(ed)));
    chk({tag, " d_valid"}, 32'(bus.d_valid), 32'(|ed));
  endtask

  task automatic drive(input logic rr, input logic [3:0] req, input logic [1:0] ht,
                       input logic [2:0] hb, input logic [3:0] lk, input logic rdy,
                       input logic [3:0] hmax);
    bus.rr_en    = rr;
    bus.m_req    = req;
    bus.m_htrans = {4{ht}};
    bus.m_hburst = {4{hb}};
    bus.m_hlock  = lk;
    bus.hready   = rdy;
    bus.hold_max = hmax;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hreset = 1'b1;
    drive(1'b0, 4'b0000, IDL, 3'd0, 4'b0000, 1'b1, 4'd0);

    // fixed priority, 1-cycle grant latency
    add(1, 0, 4'b1010, IDL, 3'd0, 4'b0000, 1, 4'd0, 4'b0010, 4'b0000);
    add(0, 0, 4'b1010, NS,  3'd0, 4'b0000, 1, 4'd0, 4'b0010, 4'b0010);
    // round-robin with all masters requesting singles
    add(1, 1, 4'b1111, NS,  3'd0, 4'b0000, 1, 4'd0, 4'b0001, 4'b0000);
    add(0, 1, 4'b1111, NS,  3'd0, 4'b0000, 1, 4'd0, 4'b0010, 4'b0001);
    add(0, 1, 4'b1111, NS,  3'd0, 4'b0000, 1, 4'd0, 4'b0100, 4'b0010);
    add(0, 1, 4'b1111, NS,  3'd0, 4'b0000, 1, 4'd0, 4'b1000, 4'b0100);
    add(0, 1, 4'b1111, NS,  3'd0, 4'b0000, 1, 4'd0, 4'b0001, 4'b1000);
    // M2 INCR8 with a BUSY beat; M2 drops req while locked, M0 waiting
    add(1, 0, 4'b0100, IDL, 3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0000);
    add(0, 0, 4'b0101, NS,  3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0100);
    add(0, 0, 4'b0001, SQ,  3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0100);
    add(0, 0, 4'b0001, SQ,  3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0100);
    add(0, 0, 4'b0001, SQ,  3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0100);
    add(0, 0, 4'b0001, BSY, 3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0000);
    add(0, 0, 4'b0001, SQ,  3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0100);
    add(0, 0, 4'b0001, SQ,  3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0100);
    add(0, 0, 4'b0001, SQ,  3'd5, 4'b0000, 1, 4'd0, 4'b0100, 4'b0100);
    add(0, 0, 4'b0001, SQ,  3'd5, 4'b0000, 1, 4'd0, 4'b0001, 4'b0100);
    add(0, 0, 4'b0001, NS,  3'd0, 4'b0000, 1, 4'd0, 4'b0001, 4'b0001);
    // M1 INCR4 aborted by IDLE after two beats
    add(1, 1, 4'b0010, IDL, 3'd3, 4'b0000, 1, 4'd0, 4'b0010, 4'b0000);
    add(0, 1, 4'b1010, NS,  3'd3, 4'b0000, 1, 4'd0, 4'b0010, 4'b0010);
    add(0, 1, 4'b1010, SQ,  3'd3, 4'b0000, 1, 4'd0, 4'b0010, 4'b0010);
    add(0, 1, 4'b1010, IDL, 3'd3, 4'b0000, 1, 4'd0, 4'b1000, 4'b0000);
    // INCR hold limit 3 with a 5-cycle stall, then unlimited (hold_max=0)
    add(1, 1, 4'b0001, IDL, 3'd1, 4'b0000, 1, 4'd3, 4'b0001, 4'b0000);
    add(0, 1, 4'b0011, NS,  3'd1, 4'b0000, 1, 4'd3, 4'b0001, 4'b0001);
    add(0, 1, 4'b0011, SQ,  3'd1, 4'b0000, 1, 4'd3, 4'b0001, 4'b0001);
    add(0, 1, 4'b0011, SQ,  3'd1, 4'b0000, 1, 4'd3, 4'b0001, 4'b0001);
    for (int i = 0; i < 5; i++)
      add(0, 1, 4'b0011, IDL, 3'd1, 4'b0000, 0, 4'd3, 4'b0001, 4'b0001);
    add(0, 1, 4'b0011, SQ,  3'd1, 4'b0000, 1, 4'd3, 4'b0010, 4'b0001);
    add(0, 1, 4'b0011, NS,  3'd1, 4'b0000, 1, 4'd0, 4'b0010, 4'b0010);
    for (int i = 0; i < 4; i++)
      add(0, 1, 4'b0011, SQ, 3'd1, 4'b0000, 1, 4'd0, 4'b0010, 4'b0010);
    add(0, 1, 4'b0011, IDL, 3'd1, 4'b0000, 1, 4'd0, 4'b0001, 4'b0000);
    // HMASTLOCK across two singles
    add(1, 1, 4'b0001, IDL, 3'd0, 4'b0000, 1, 4'd0, 4'b0001, 4'b0000);
    add(0, 1, 4'b0011, NS,  3'd0, 4'b0001, 1, 4'd0, 4'b0001, 4'b0001);
    add(0, 1, 4'b0011, NS,  3'd0, 4'b0001, 1, 4'd0, 4'b0001, 4'b0001);
    add(0, 1, 4'b0011, NS,  3'd0, 4'b0000, 1, 4'd0, 4'b0010, 4'b0001);

    @(posedge hclk);
    @(posedge hclk);
    #1;
    chk_all("reset", 4'b0000, 4'b0000);

    for (int n = 0; n < vecs.size(); n++) begin
      if (vecs[n].rs) do_reset();
      drive(vecs[n].rr, vecs[n].req, vecs[n].ht, vecs[n].hb, vecs[n].lk,
            vecs[n].rdy, vecs[n].hmax);
      @(posedge hclk);
      #1;
      chk_all($sformatf("vec%0d", n), vecs[n].eg, vecs[n].ed);
    end

    // Mid-burst asynchronous reset; afterwards ptr and cnt must be back at reset values.
    drive(1'b1, 4'b0010, NS, 3'd5, 4'b0000, 1'b1, 4'd0);
    @(posedge hclk);
    #1;
    chk_all("mb_start", 4'b0010, 4'b0010);
    drive(1'b1, 4'b0010, SQ, 3'd5, 4'b0000, 1'b1, 4'd0);
    @(posedge hclk);
    #2;
    hreset = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 4'b0000);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    drive(1'b1, 4'b1010, IDL, 3'd5, 4'b0000, 1'b1, 4'd0);
    @(posedge hclk);
    #1;
    chk_all("post_rst_ptr", 4'b0010, 4'b0000);
    drive(1'b1, 4'b1010, SQ, 3'd5, 4'b0000, 1'b1, 4'd0);
    @(posedge hclk);
    #1;
    chk_all("post_rst_cnt", 4'b1000, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
